// File: rtl/xyz_to_cct_estimator.sv
// McCamy correlated-colour-temperature estimator: XYZ (Q16.16) in, kelvin out.
// Multi-cycle: one setup cycle, a bit-serial divider, a shared-multiplier Horner polynomial, then a rounding/clamp cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for xyz_valid; latches X,Y,Z on accept
// S_SETUP | forms S, num = X-K1*S, den = K2*S-Y and the degenerate flag
// S_DIV   | restoring divide |num|<<16 / |den|, one quotient bit per cycle
// S_POLY  | three Horner steps on the shared 32x32 multiplier
// S_FINAL | round, clamp or default, raise cct_valid
module xyz_to_cct_estimator #(
   parameter int CCT_MIN     = 3000,
   parameter int CCT_MAX     = 8000,
   parameter int CCT_DEFAULT = 6500,
   parameter int DIV_ITERS   = 48
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] xyz_in [2:0],
   input  logic        xyz_valid,
   output logic [15:0] cct_out,
   output logic        cct_valid,
   output logic        cct_clamped,
   output logic        cct_err,
   output logic        busy
);

   localparam logic [14:0] K1 = 15'd21758;
   localparam logic [14:0] K2 = 15'd12177;
   localparam logic signed [31:0] C1 = 32'sd29425664;
   localparam logic signed [31:0] C2 = 32'sd231014400;
   localparam logic signed [31:0] C3 = 32'sd447171789;
   localparam logic signed [31:0] C4 = 32'sd361780347;
   localparam int REM_W = 41;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DIV, S_POLY, S_FINAL} state_t;

   state_t                 state;
   logic [7:0]             cnt;
   logic [31:0]            xyz_r [2:0];
   logic                   q_neg;
   logic                   ovf;
   logic                   err_r;
   logic [39:0]            den_mag_r;
   logic [DIV_ITERS-1:0]   dvd_r;
   logic [DIV_ITERS-1:0]   quo;
   logic [REM_W-1:0]       rem;
   logic signed [31:0]     acc;

   // setup datapath
   logic [33:0]        s_sum;
   logic [48:0]        k1s, k2s;
   logic [32:0]        k1r, k2r;
   logic signed [39:0] num, den;
   logic [39:0]        num_mag, den_mag;
   logic [55:0]        dvd, dvd_top;

   always_comb begin
      s_sum   = {2'b0, xyz_r[0]} + {2'b0, xyz_r[1]} + {2'b0, xyz_r[2]};
      k1s     = {15'b0, s_sum} * {34'b0, K1};
      k2s     = {15'b0, s_sum} * {34'b0, K2};
      k1r     = 33'((k1s + 49'h8000) >> 16);
      k2r     = 33'((k2s + 49'h8000) >> 16);
      num     = $signed({8'b0, xyz_r[0]}) - $signed({7'b0, k1r});
      den     = $signed({7'b0, k2r}) - $signed({8'b0, xyz_r[1]});
      num_mag = num[39] ? 40'(-num) : 40'(num);
      den_mag = den[39] ? 40'(-den) : 40'(den);
      dvd     = {num_mag, 16'b0};
      dvd_top = dvd >> DIV_ITERS;
   end

   // divider step
   logic [REM_W-1:0] trial;
   logic             take;

   always_comb begin
      trial = {rem[REM_W-2:0], dvd_r[DIV_ITERS-1]};
      take  = trial >= {1'b0, den_mag_r};
   end

   // saturated quotient and Horner step
   logic [31:0]        n_mag;
   logic signed [31:0] n_val;
   logic signed [63:0] prod, prod_sh;
   logic signed [31:0] prod_sat, coef, sum_sat;
   logic signed [32:0] sum33;

   always_comb begin
      n_mag = (ovf || (|quo[DIV_ITERS-1:31])) ? 32'h7fff_ffff : {1'b0, quo[30:0]};
      n_val = q_neg ? -$signed(n_mag) : $signed(n_mag);
      prod    = acc * n_val;
      prod_sh = prod >>> 16;
      if (prod_sh > 64'sh7fff_ffff)
         prod_sat = 32'sh7fff_ffff;
      else if (prod_sh < -64'sh8000_0000)
         prod_sat = -32'sh7fff_ffff - 32'sd1;
      else
         prod_sat = prod_sh[31:0];
      case (cnt)
         8'd0:    coef = C2;
         8'd1:    coef = C3;
         default: coef = C4;
      endcase
      sum33 = {prod_sat[31], prod_sat} + {coef[31], coef};
      if (sum33[32] != sum33[31])
         sum_sat = sum33[32] ? (-32'sh7fff_ffff - 32'sd1) : 32'sh7fff_ffff;
      else
         sum_sat = sum33[31:0];
   end

   // final rounding
   logic signed [32:0] rnd;

   always_comb begin
      rnd = ($signed({acc[31], acc}) + 33'sh8000) >>> 16;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         xyz_r       <= '{default: '0};
         q_neg       <= 1'b0;
         ovf         <= 1'b0;
         err_r       <= 1'b0;
         den_mag_r   <= '0;
         dvd_r       <= '0;
         quo         <= '0;
         rem         <= '0;
         acc         <= '0;
         cct_out     <= 16'(CCT_DEFAULT);
         cct_valid   <= 1'b0;
         cct_clamped <= 1'b0;
         cct_err     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         cct_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (xyz_valid) begin
                  xyz_r <= xyz_in;
                  busy  <= 1'b1;
                  state <= S_SETUP;
               end
            end
            S_SETUP: begin
               q_neg     <= num[39] ^ den[39];
               den_mag_r <= den_mag;
               dvd_r     <= dvd[DIV_ITERS-1:0];
               rem       <= REM_W'(dvd_top);
               // quotient would not fit in DIV_ITERS bits: it saturates anyway
               ovf       <= dvd_top >= {16'b0, den_mag};
               err_r     <= (s_sum == '0) || (den == '0);
               quo       <= '0;
               acc       <= C1;
               cnt       <= '0;
               state     <= S_DIV;
            end
            S_DIV: begin
               rem   <= take ? (trial - {1'b0, den_mag_r}) : trial;
               quo   <= {quo[DIV_ITERS-2:0], take};
               dvd_r <= dvd_r << 1;
               if (cnt == 8'(DIV_ITERS - 1)) begin
                  cnt   <= '0;
                  state <= S_POLY;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_POLY: begin
               acc <= sum_sat;
               if (cnt == 8'd2) begin
                  cnt   <= '0;
                  state <= S_FINAL;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_FINAL: begin
               cct_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= S_IDLE;
               if (err_r) begin
                  cct_out     <= 16'(CCT_DEFAULT);
                  cct_err     <= 1'b1;
                  cct_clamped <= 1'b0;
               end else if (rnd < $signed(33'(CCT_MIN))) begin
                  cct_out     <= 16'(CCT_MIN);
                  cct_err     <= 1'b0;
                  cct_clamped <= 1'b1;
               end else if (rnd > $signed(33'(CCT_MAX))) begin
                  cct_out     <= 16'(CCT_MAX);
                  cct_err     <= 1'b0;
                  cct_clamped <= 1'b1;
               end else begin
                  cct_out     <= rnd[15:0];
                  cct_err     <= 1'b0;
                  cct_clamped <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xyz_to_cct_estimator.sv
// Directed bench for xyz_to_cct_estimator: vector table of illuminants plus
// hand-written sequences for back-to-back, busy-ignore and mid-divide reset.
module tb_xyz_to_cct_estimator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] xyz_in [2:0];
   logic        xyz_valid;
   logic [15:0] cct_out;
   logic        cct_valid;
   logic        cct_clamped;
   logic        cct_err;
   logic        busy;

   xyz_to_cct_estimator dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .xyz_in      (xyz_in),
      .xyz_valid   (xyz_valid),
      .cct_out     (cct_out),
      .cct_valid   (cct_valid),
      .cct_clamped (cct_clamped),
      .cct_err     (cct_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] x, y, z;
      int          exp_cct;
      int          tol;
      logic        exp_clamp;
      logic        exp_err;
   } vec_t;

   vec_t vecs [5];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int n_valid = 0;
   int t_acc;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (cct_valid) n_valid = n_valid + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_tol(input string name, input int act, input int exp, input int tol);
      tests++;
      if (act < exp - tol || act > exp + tol) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   task automatic start(input vec_t v);
      xyz_in[0] = v.x;
      xyz_in[1] = v.y;
      xyz_in[2] = v.z;
      xyz_valid = 1'b1;
      @(posedge clk);
      #1;
      xyz_valid = 1'b0;
      t_acc = cyc;
   endtask

   task automatic wait_result(output int lat);
      lat = -1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (cct_valid) begin
            lat = cyc - t_acc;
            break;
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      start(v);
      check({v.name, " busy after accept"}, int'(busy), 1);
      wait_result(lat);
      check({v.name, " latency"}, lat, 53);
      check_tol({v.name, " cct"}, int'(cct_out), v.exp_cct, v.tol);
      check({v.name, " clamped"}, int'(cct_clamped), int'(v.exp_clamp));
      check({v.name, " err"}, int'(cct_err), int'(v.exp_err));
   endtask

   initial begin
      int lat, t_first, nv0;
      vec_t va;

      vecs[0] = '{"d65",  32'd62292, 32'd65536, 32'd71369, 6505, 5, 1'b0, 1'b0};
      vecs[1] = '{"d50",  32'd63190, 32'd65536, 32'd54074, 5001, 5, 1'b0, 1'b0};
      vecs[2] = '{"illA", 32'd71991, 32'd65536, 32'd23318, 3000, 0, 1'b1, 1'b0};
      vecs[3] = '{"hot",  32'd63786, 32'd65536, 32'd96554, 8000, 0, 1'b1, 1'b0};
      vecs[4] = '{"zero", 32'd0,     32'd0,     32'd0,     6500, 0, 1'b0, 1'b1};

      rst_n = 1'b0;
      xyz_valid = 1'b0;
      xyz_in[0] = '0;
      xyz_in[1] = '0;
      xyz_in[2] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset cct_out", int'(cct_out), 6500);
      check("reset cct_valid", int'(cct_valid), 0);
      check("reset busy", int'(busy), 0);
      check("reset clamped", int'(cct_clamped), 0);
      check("reset err", int'(cct_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i]);
         repeat (3) @(negedge clk);
      end

      // back-to-back: new request during the cct_valid cycle
      start(vecs[1]);
      wait_result(lat);
      check_tol("b2b first cct", int'(cct_out), 5001, 5);
      t_first = cyc;
      check("b2b valid at reissue", int'(cct_valid), 1);
      start(vecs[0]);
      wait_result(lat);
      check("b2b spacing", cyc - t_first, 54);
      check_tol("b2b second cct", int'(cct_out), 6505, 5);
      repeat (3) @(negedge clk);

      // request while busy must be dropped
      nv0 = n_valid;
      start(vecs[0]);
      repeat (10) @(posedge clk);
      #1;
      va = vecs[2];
      xyz_in[0] = va.x;
      xyz_in[1] = va.y;
      xyz_in[2] = va.z;
      xyz_valid = 1'b1;
      @(posedge clk);
      #1;
      xyz_valid = 1'b0;
      wait_result(lat);
      check("busy-ignore latency", lat, 53);
      check_tol("busy-ignore cct", int'(cct_out), 6505, 5);
      check("busy-ignore clamped", int'(cct_clamped), 0);
      repeat (60) @(posedge clk);
      #1;
      check("busy-ignore result count", n_valid - nv0, 1);
      check("busy-ignore idle", int'(busy), 0);

      // reset in the middle of the divide
      start(vecs[0]);
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst busy", int'(busy), 0);
      check("midrst cct_out", int'(cct_out), 6500);
      check("midrst valid", int'(cct_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      nv0 = n_valid;
      repeat (60) @(posedge clk);
      #1;
      check("midrst no result", n_valid - nv0, 0);
      @(negedge clk);
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
